key_conditioner: RTL and testbench
==================================

# key_conditioner

Input conditioning stage in front of the PUF select FSM. It synchronizes and debounces the two DE0-Nano push-buttons and turns each press into a single-cycle, active-low KEY pulse. It also provides an auto-sweep sequencer that generates the alternating KEY[0]/KEY[1] pulse train needed to walk the FSM through all challenges without manual presses. Its `key_out` drives the FSM `KEY` input directly. Its `halt_in` is driven by the FSM present state being HALT.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required to accept a new button level (1 ms at 50 MHz). Legal range ≥ 1.
- `AUTO_PERIOD`, default 50000: cycles between auto-generated pulses. Legal range ≥ 2.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `key_raw`  in  2  raw push-buttons, active-low (0 = pressed), asynchronous to `clk`.
- `auto_en`  in  1  level; 1 = auto-sweep mode.
- `halt_in`  in  1  level; 1 = downstream FSM is in HALT.
- `key_out`  out  2  conditioned keys, active-low; idle 2'b11; a press is one cycle of 0.
- `auto_busy`  out  1  1 while the sequencer is in A_K0 or A_K1.
- `press_count`  out  8  number of manual pulses emitted on either bit, wraps 255→0.

## Operation
- Synchronizer: each `key_raw` bit passes through a 2-FF chain. Reset value is 1 (released).
- Debouncer, per bit:
  - Registered `stable` level, reset 1, and a counter of width `$clog2(DEBOUNCE_CYCLES+1)`, reset 0.
  - When the sync output equals `stable`, the counter clears.
  - Otherwise the counter increments. When it reaches `DEBOUNCE_CYCLES`, `stable` takes the sync value and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes `stable`.
- Manual pulse: a 1→0 transition of `stable` produces a one-cycle manual request for that bit. A 0→1 transition (release) produces nothing.
- Simultaneous manual requests on both bits in the same cycle: only bit 0 is emitted; the bit 1 request is dropped.
- While `auto_en` = 1, manual requests are discarded and not counted. Debouncers keep tracking.
- `press_count` increments by 1 per emitted manual pulse.
- Auto sequencer states: A_IDLE, A_K0, A_K1, A_DONE. Reset state is A_IDLE. The period timer resets to 0.
  - A_IDLE → A_K0 when `auto_en` = 1. The timer clears.
  - A_K0 / A_K1: the timer counts 0..`AUTO_PERIOD`-1. At terminal count the state emits its pulse (A_K0 on `key_out[0]`, A_K1 on `key_out[1]`), clears the timer, and moves to the other state.
  - Any state except A_IDLE → A_IDLE when `auto_en` = 0. This has priority over everything else; no pulse is emitted that cycle and the timer clears.
  - A_K0/A_K1 → A_DONE when `halt_in` = 1. This has priority over the terminal-count pulse. A_DONE holds until `auto_en` = 0.
- Output: `key_out[i]` = NOT(manual pulse i OR auto pulse i), registered. In auto mode at most one bit is low per cycle.

## Timing
- Reset values: `key_out` = 2'b11, `auto_busy` = 0, `press_count` = 0, all internal counters 0, `stable` = 2'b11.
- Manual latency: counting from the first rising edge that samples a new `key_raw` level:
  - sync output valid after edge 2.
  - `stable` updates on edge `DEBOUNCE_CYCLES`+2.
  - `key_out` goes low for exactly one cycle after edge `DEBOUNCE_CYCLES`+3.
- Holding a button produces exactly one pulse. A further pulse requires a debounced release followed by a debounced press.
- Auto: the first `key_out[0]` pulse appears `AUTO_PERIOD`+1 edges after the edge that sees `auto_en` = 1. Subsequent pulses follow every `AUTO_PERIOD` cycles, alternating 0,1,0,1…
- `auto_busy` is registered and tracks the state one cycle after the transition.
- `rst_n` low mid-operation: all state clears immediately and asynchronously, including any in-flight pulse. `key_out` reads 2'b11 during reset and for at least one cycle after release.
- `press_count` wraps: 255 + one press = 0.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `AUTO_PERIOD`=8.
- Reset: assert `rst_n`=0 mid-count. Required: `key_out`=11, `auto_busy`=0, `press_count`=0 immediately; no pulse after release.
- Clean press: hold `key_raw[1]`=0 for 20 cycles. Required: a single `key_out`=2'b01 pulse, 7 edges after the first sampling edge; `press_count`=1; release gives no pulse.
- Bounce: `key_raw[0]` toggles low for 3 cycles and high for 1, repeated 5×. Required: no pulse. Then hold low for 10 cycles: exactly one `key_out`=2'b10 pulse.
- Simultaneous press: both bits go low on the same edge and are held. Required: only `key_out`=2'b10 for one cycle; `press_count` increments by 1.
- Auto sweep: `auto_en`=1 with manual presses injected. Required:
  - pulses 10,01,10,01 spaced 8 cycles apart, first at edge 9;
  - manual presses ignored;
  - `halt_in`=1 on a terminal-count cycle yields no pulse, A_DONE, `auto_busy`=0;
  - `auto_en`=0 returns the sequencer to A_IDLE.
- Wrap: 256 manual presses. Required: `press_count` returns to 0.

Source files
------------

// File: rtl/key_conditioner.sv
// Push-button conditioner: 2-FF sync, per-bit debounce, one-cycle active-low press pulses,
// plus an auto-sweep sequencer that alternates KEY[0]/KEY[1] pulses until the FSM halts.
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int AUTO_PERIOD     = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] key_raw,
    input  logic       auto_en,
    input  logic       halt_in,
    output logic [1:0] key_out,
    output logic       auto_busy,
    output logic [7:0] press_count
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(AUTO_PERIOD);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(AUTO_PERIOD - 1);

    typedef enum logic [1:0] {A_IDLE, A_K0, A_K1, A_DONE} auto_state_t;

    logic [1:0]    sync_p0, sync_p1;
    logic [1:0]    stable, stable_d;
    logic [DW-1:0] deb_cnt [2];
    logic [1:0]    fall, man_pulse;
    logic [1:0]    auto_req, auto_pulse;
    logic [TW-1:0] timer, timer_next;
    auto_state_t   state, state_next;

    // Synchronizer and debouncer; the counter only runs while sync disagrees with stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0  <= 2'b11;
            sync_p1  <= 2'b11;
            stable   <= 2'b11;
            stable_d <= 2'b11;
            for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
        end else begin
            sync_p0  <= key_raw;
            sync_p1  <= sync_p0;
            stable_d <= stable;
            for (int i = 0; i < 2; i++) begin
                if (sync_p1[i] == stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    stable[i]  <= sync_p1[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Press edges; bit 0 wins a tie, and auto mode swallows manual presses entirely
    always_comb begin
        fall      = stable_d & ~stable;
        man_pulse = 2'b00;
        if (!auto_en) begin
            if (fall[0])      man_pulse = 2'b01;
            else if (fall[1]) man_pulse = 2'b10;
        end
    end

    always_comb begin
        state_next = state;
        timer_next = timer;
        auto_req   = 2'b00;
        case (state)
            A_IDLE: begin
                if (auto_en) begin
                    state_next = A_K0;
                    timer_next = '0;
                end
            end
            A_K0, A_K1: begin
                if (!auto_en) begin
                    state_next = A_IDLE;
                    timer_next = '0;
                end else if (halt_in) begin
                    state_next = A_DONE;
                    timer_next = '0;
                end else if (timer == TIMER_LAST) begin
                    auto_req   = (state == A_K0) ? 2'b01 : 2'b10;
                    state_next = (state == A_K0) ? A_K1 : A_K0;
                    timer_next = '0;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            A_DONE: begin
                if (!auto_en) begin
                    state_next = A_IDLE;
                    timer_next = '0;
                end
            end
            default: begin
                state_next = A_IDLE;
                timer_next = '0;
            end
        endcase
    end

    // Output stage: auto pulses take one extra register so the first lands AUTO_PERIOD+1 edges in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= A_IDLE;
            timer       <= '0;
            auto_pulse  <= 2'b00;
            auto_busy   <= 1'b0;
            key_out     <= 2'b11;
            press_count <= 8'd0;
        end else begin
            state      <= state_next;
            timer      <= timer_next;
            auto_pulse <= auto_req;
            auto_busy  <= (state == A_K0) || (state == A_K1);
            key_out    <= ~(man_pulse | auto_pulse);
            if (|man_pulse) press_count <= press_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: random button/auto stimulus, a rule-level model
// predicts each key_out pulse (value, edge, press_count) and a monitor consumes them.
module tb_key_conditioner;
    localparam int DEB = 4;
    localparam int PER = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] key_raw = 2'b11;
    logic       auto_en = 1'b0;
    logic       halt_in = 1'b0;
    logic [1:0] key_out;
    logic       auto_busy;
    logic [7:0] press_count;

    always #5 clk = ~clk;

    key_conditioner #(.DEBOUNCE_CYCLES(DEB), .AUTO_PERIOD(PER)) dut (
        .clk(clk), .rst_n(rst_n), .key_raw(key_raw), .auto_en(auto_en),
        .halt_in(halt_in), .key_out(key_out), .auto_busy(auto_busy),
        .press_count(press_count)
    );

    typedef struct { logic [1:0] val; int edge_no; logic [7:0] cnt; } exp_t;
    exp_t q[$];

    int edge_n = 0;
    int nchecks = 0;
    int nerrs = 0;
    int seen_pulses = 0;
    int last_pulse_edge = -1;
    logic [1:0] last_pulse_val = 2'b11;

    // Reference model state
    logic [1:0] m_st;
    int         m_run [2];
    logic [7:0] m_cnt;
    bit         m_active, m_done, m_bit;
    int         m_next;
    int         auto_pulses;

    function automatic void chk(input string name, input int act, input int want);
        nchecks++;
        if (act != want) begin
            nerrs++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at edge %0d",
                     name, act, act, want, want, edge_n);
        end
    endfunction

    function automatic void model_reset();
        m_st = 2'b11; m_run[0] = 0; m_run[1] = 0; m_cnt = 8'd0;
        m_active = 0; m_done = 0; m_bit = 0; m_next = 0;
        q.delete();
    endfunction

    // A level is accepted after DEB consecutive samples at the new value; the pulse shows 3 edges
    // after the DEB-th sample. Auto pulses land PER+1 edges after enable, then every PER.
    function automatic void model_sample(input logic [1:0] raw, input logic ae, input logic h, input int e);
        logic [1:0] f = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (raw[i] != m_st[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_st[i] = raw[i];
                    m_run[i] = 0;
                    if (raw[i] == 1'b0) f[i] = 1'b1;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        if (f != 2'b00 && !ae) begin
            m_cnt++;
            q.push_back('{f[0] ? 2'b10 : 2'b01, e + 3, m_cnt});
        end
        if (!ae) begin
            m_active = 0; m_done = 0;
        end else if (m_active) begin
            if (h) begin
                m_active = 0; m_done = 1;
            end else if (e == m_next - 1) begin
                q.push_back('{m_bit ? 2'b01 : 2'b10, m_next, m_cnt});
                m_next += PER;
                m_bit = !m_bit;
                auto_pulses++;
            end
        end else if (!m_done) begin
            m_active = 1; m_next = e + PER + 1; m_bit = 0;
        end
    endfunction

    task automatic step(input logic [1:0] raw, input logic ae, input logic h);
        bit busy_exp;
        key_raw = raw; auto_en = ae; halt_in = h;
        busy_exp = m_active;
        model_sample(raw, ae, h, edge_n + 1);
        @(posedge clk);
        edge_n++;
        #1;
        chk("auto_busy", int'(auto_busy), int'(busy_exp));
    endtask

    task automatic hold(input logic [1:0] raw, input int n);
        for (int k = 0; k < n; k++) step(raw, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        while (q.size() > 0 && q[0].edge_no < edge_n) begin
            chk("missed_pulse_edge", edge_n, q[0].edge_no);
            void'(q.pop_front());
        end
        if (rst_n && key_out !== 2'b11) begin
            seen_pulses++;
            last_pulse_edge = edge_n;
            last_pulse_val = key_out;
            if (q.size() == 0) begin
                chk("unexpected_pulse", int'(key_out), 3);
            end else begin
                e = q.pop_front();
                chk("key_out", int'(key_out), int'(e.val));
                chk("pulse_edge", edge_n, e.edge_no);
                chk("press_count", int'(press_count), int'(e.cnt));
            end
        end
    end

    initial begin
        int f, n, guard, seen0;
        logic [1:0] raw;
        logic h;
        model_reset();
        repeat (2) begin @(posedge clk); edge_n++; end
        #1;
        chk("rst_key_out", int'(key_out), 3);
        chk("rst_auto_busy", int'(auto_busy), 0);
        chk("rst_press_count", int'(press_count), 0);
        #2 rst_n = 1'b1;

        // Clean press on bit 1
        hold(2'b11, 4);
        f = edge_n + 1;
        hold(2'b01, 20);
        hold(2'b11, 20);
        chk("clean_latency", last_pulse_edge, f + DEB + 2);
        chk("clean_val", int'(last_pulse_val), 1);
        chk("clean_count", int'(press_count), 1);

        // Bounce on bit 0, then a real hold
        seen0 = seen_pulses;
        for (int r = 0; r < 5; r++) begin hold(2'b10, 3); hold(2'b11, 1); end
        chk("bounce_no_pulse", seen_pulses - seen0, 0);
        hold(2'b10, 10);
        hold(2'b11, 12);
        chk("bounce_pulses", seen_pulses - seen0, 1);
        chk("bounce_val", int'(last_pulse_val), 2);

        // Simultaneous press
        seen0 = seen_pulses;
        hold(2'b00, 12);
        hold(2'b11, 12);
        chk("simul_pulses", seen_pulses - seen0, 1);
        chk("simul_val", int'(last_pulse_val), 2);
        chk("simul_count", int'(press_count), 3);

        // Reset in the middle of a debounce count
        hold(2'b01, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_key_out", int'(key_out), 3);
        chk("midrst_auto_busy", int'(auto_busy), 0);
        chk("midrst_press_count", int'(press_count), 0);
        model_reset();
        key_raw = 2'b11;
        repeat (3) begin @(posedge clk); edge_n++; end
        #3 rst_n = 1'b1;
        step(2'b11, 1'b0, 1'b0);
        chk("post_rst_key_out", int'(key_out), 3);
        hold(2'b11, 15);

        // Auto sweep with random manual noise; halt lands on the fifth terminal count
        seen0 = seen_pulses;
        auto_pulses = 0;
        guard = 0;
        while (!m_done && guard < 300) begin
            raw = 2'($urandom_range(0, 3));
            n = $urandom_range(1, 8);
            for (int k = 0; k < n && !m_done; k++) begin
                h = (auto_pulses == 4 && m_active && (edge_n + 1 == m_next - 1));
                step(raw, 1'b1, h);
                guard++;
            end
        end
        chk("auto_reached_halt", guard < 300 ? 1 : 0, 1);
        for (int k = 0; k < 2 * DEB + 4; k++) step(2'b11, 1'b1, 1'b1);
        chk("auto_pulse_count", seen_pulses - seen0, 4);
        chk("auto_done_busy", int'(auto_busy), 0);
        chk("auto_ignores_manual", int'(press_count), 0);

        // Drop auto_en, re-enable: sequencer restarts from A_IDLE
        for (int k = 0; k < 5; k++) step(2'b11, 1'b0, 1'b0);
        seen0 = seen_pulses;
        for (int k = 0; k < PER + 3; k++) step(2'b11, 1'b1, 1'b0);
        guard = 0;
        while (edge_n + 1 != m_next - 3 && guard < 3 * PER) begin
            step(2'b11, 1'b1, 1'b0);
            guard++;
        end
        for (int k = 0; k < 10; k++) step(2'b11, 1'b0, 1'b0);
        chk("restart_pulses", seen_pulses - seen0, 1);
        chk("restart_val", int'(last_pulse_val), 2);
        chk("restart_idle_busy", int'(auto_busy), 0);

        // press_count wrap after 256 presses from reset
        #2 rst_n = 1'b0;
        model_reset();
        @(posedge clk); edge_n++;
        #3 rst_n = 1'b1;
        hold(2'b11, 3);
        for (int p = 0; p < 256; p++) begin
            raw = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
            hold(raw, $urandom_range(DEB, DEB + 3));
            hold(2'b11, $urandom_range(DEB, DEB + 3));
        end
        hold(2'b11, 8);
        chk("wrap_count", int'(press_count), 0);

        // Random manual noise
        for (int r = 0; r < 60; r++) begin
            raw = 2'($urandom_range(0, 3));
            hold(raw, $urandom_range(1, 7));
        end
        hold(2'b11, 2 * DEB + 8);
        chk("queue_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
        $finish;
    end
endmodule
